// File: rtl/pcr_bridge_pkg.sv
// Shared types and constants for the PCR host bridge.
//   PCR_ADDR_W / PCR_DATA_W : default PCR address and data widths
//   bridge_state_t          : issue FSM states (IDLE, ISSUE, RESP)
//   pcr_req_t               : one buffered host request {rw, addr, data}
package pcr_bridge_pkg;

    localparam int PCR_ADDR_W = 5;
    localparam int PCR_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } bridge_state_t;

    typedef struct packed {
        logic                  rw;
        logic [PCR_ADDR_W-1:0] addr;
        logic [PCR_DATA_W-1:0] data;
    } pcr_req_t;

endpackage

// File: rtl/pcr_host_bridge_if.sv
// Bundle of the host request/response handshakes and the PCR file access port.
//   host_req_*  : request channel (valid/ready, rw, addr, data)
//   host_resp_* : response channel (valid/ready, data = pre-access value)
//   pcr_*       : single-cycle access port towards the PCR file
// Modports: slave = bridge side, master = host plus PCR file side.
interface pcr_host_bridge_if #(
    parameter int ADDR_W = pcr_bridge_pkg::PCR_ADDR_W,
    parameter int DATA_W = pcr_bridge_pkg::PCR_DATA_W
);
    logic              host_req_valid;
    logic              host_req_ready;
    logic              host_req_rw;
    logic [ADDR_W-1:0] host_req_addr;
    logic [DATA_W-1:0] host_req_data;
    logic              host_resp_valid;
    logic              host_resp_ready;
    logic [DATA_W-1:0] host_resp_data;
    logic              pcr_en;
    logic              pcr_wen;
    logic [ADDR_W-1:0] pcr_addr;
    logic [DATA_W-1:0] pcr_wdata;
    logic [DATA_W-1:0] pcr_rdata;

    modport slave (
        input  host_req_valid, host_req_rw, host_req_addr, host_req_data,
        input  host_resp_ready, pcr_rdata,
        output host_req_ready, host_resp_valid, host_resp_data,
        output pcr_en, pcr_wen, pcr_addr, pcr_wdata
    );

    modport master (
        output host_req_valid, host_req_rw, host_req_addr, host_req_data,
        output host_resp_ready, pcr_rdata,
        input  host_req_ready, host_resp_valid, host_resp_data,
        input  pcr_en, pcr_wen, pcr_addr, pcr_wdata
    );
endinterface

// File: rtl/pcr_req_fifo.sv
// Synchronous request FIFO for the PCR host bridge.
//   clk, reset : clock and synchronous active-high reset (flushes contents)
//   push, din  : write din at the tail (ignored while full)
//   pop        : drop the head (ignored while empty)
//   dout       : current head entry, combinational
//   full/empty : derived from the registered occupancy count
// A simultaneous push and pop keeps the count; the pop always removes the
// old head, never the entry being written.
module pcr_req_fifo
    import pcr_bridge_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  logic     pop,
    input  pcr_req_t din,
    output pcr_req_t dout,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    pcr_req_t         mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign dout      = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; cleared on reset so no stale request survives a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/pcr_host_bridge.sv
// Host-to-PCR-file bridge with swap semantics.
//   clk, reset : clock and synchronous active-high reset
//   bus        : pcr_host_bridge_if.slave (host request/response + PCR port)
// Requests are buffered in pcr_req_fifo and issued one at a time as a single
// pcr_en cycle; the pre-access register value is returned on the response
// channel. pcr_addr/pcr_wdata/pcr_wen double as the issue registers: they are
// only loaded on a pop, which is also the edge that enters ISSUE, so they
// never move outside an access.
module pcr_host_bridge
    import pcr_bridge_pkg::*;
#(
    parameter int ADDR_W = PCR_ADDR_W,
    parameter int DATA_W = PCR_DATA_W,
    parameter int DEPTH  = 2
) (
    input logic              clk,
    input logic              reset,
    pcr_host_bridge_if.slave bus
);

    bridge_state_t     state_r;
    bridge_state_t     state_next_s;
    pcr_req_t          push_data_s;
    pcr_req_t          head_s;
    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              empty_s;
    logic              pcr_en_r;
    logic              pcr_wen_r;
    logic [ADDR_W-1:0] pcr_addr_r;
    logic [DATA_W-1:0] pcr_wdata_r;
    logic              resp_valid_r;
    logic [DATA_W-1:0] resp_data_r;

    // Ready comes from the registered count only, so a pop in the same cycle
    // never lets a request fall through into a full FIFO.
    assign bus.host_req_ready = !reset && !full_s;
    assign push_s             = bus.host_req_valid && bus.host_req_ready;
    assign push_data_s        = {bus.host_req_rw, bus.host_req_addr, bus.host_req_data};

    pcr_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (push_data_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Next-state and pop decision for the issue FSM.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                state_next_s = RESP;
            end
            RESP: begin
                if (bus.host_resp_ready) begin
                    if (!empty_s) begin
                        pop_s        = 1'b1;
                        state_next_s = ISSUE;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered PCR port and response channel, decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcr_en_r     <= 1'b0;
            pcr_wen_r    <= 1'b0;
            pcr_addr_r   <= {ADDR_W{1'b0}};
            pcr_wdata_r  <= {DATA_W{1'b0}};
            resp_valid_r <= 1'b0;
            resp_data_r  <= {DATA_W{1'b0}};
        end else begin
            pcr_en_r     <= (state_next_s == ISSUE);
            resp_valid_r <= (state_next_s == RESP);
            if (pop_s) begin
                pcr_wen_r   <= head_s.rw;
                pcr_addr_r  <= head_s.addr;
                pcr_wdata_r <= head_s.data;
            end
            // Old value is sampled before the write edge takes effect.
            if (state_r == ISSUE) begin
                resp_data_r <= bus.pcr_rdata;
            end
        end
    end

    assign bus.pcr_en          = pcr_en_r;
    assign bus.pcr_wen         = pcr_wen_r;
    assign bus.pcr_addr        = pcr_addr_r;
    assign bus.pcr_wdata       = pcr_wdata_r;
    assign bus.host_resp_valid = resp_valid_r;
    assign bus.host_resp_data  = resp_data_r;

endmodule

// File: tb/tb_pcr_host_bridge.sv
// Directed self-checking bench for pcr_host_bridge with a behavioural PCR file.
module tb_pcr_host_bridge;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    // PCR file model: combinational read, write at the edge closing pcr_en.
    logic [DATA_W-1:0] pcr_mem [32];
    logic              preload_en = 1'b0;
    logic [ADDR_W-1:0] preload_addr;
    logic [DATA_W-1:0] preload_data;

    // Fixed contents used by the backpressure and reset scenarios.
    logic [ADDR_W-1:0] req_addr [4] = '{5'd1, 5'd2, 5'd4, 5'd5};
    logic [DATA_W-1:0] val1 = 64'h1111_0000_0000_0001;
    logic [DATA_W-1:0] val2 = 64'h2222_0000_0000_0002;
    logic [DATA_W-1:0] val4 = 64'h4444_0000_0000_0004;
    logic [DATA_W-1:0] val5 = 64'h5555_0000_0000_0005;

    // Protocol monitor counters.
    int                overlap_err = 0;
    int                toggle_err  = 0;
    logic              prev_rst    = 1'b1;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_wdata;
    logic              prev_wen;

    pcr_host_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pcr_host_bridge #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.pcr_rdata = pcr_mem[bus.pcr_addr];

    always @(posedge clk) begin
        if (preload_en) begin
            pcr_mem[preload_addr] <= preload_data;
        end else if (bus.pcr_en && bus.pcr_wen) begin
            pcr_mem[bus.pcr_addr] <= bus.pcr_wdata;
        end
    end

    // No access while a response is pending; access fields frozen outside ISSUE.
    always @(negedge clk) begin
        if (bus.pcr_en && bus.host_resp_valid) overlap_err++;
        if (!prev_rst && !bus.pcr_en &&
            (bus.pcr_addr !== prev_addr || bus.pcr_wdata !== prev_wdata || bus.pcr_wen !== prev_wen))
            toggle_err++;
        prev_addr  = bus.pcr_addr;
        prev_wdata = bus.pcr_wdata;
        prev_wen   = bus.pcr_wen;
        prev_rst   = reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        preload_en   = 1'b1;
        preload_addr = a;
        preload_data = d;
        tick();
        preload_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset                = 1'b1;
        bus.host_req_valid   = 1'b0;
        bus.host_req_rw      = 1'b0;
        bus.host_req_addr    = 5'd0;
        bus.host_req_data    = 64'd0;
        bus.host_resp_ready  = 1'b0;
        tick();
        preload(5'd0, 64'h11);
        preload(5'd3, 64'hA5);
        preload(5'd1, val1);
        preload(5'd2, val2);
        preload(5'd4, val4);
        preload(5'd5, val5);
        preload(5'd6, 64'h66);
        preload(5'd7, 64'h77);
        checks++; if (bus.host_req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.host_req_ready); end
        checks++; if (bus.host_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", bus.host_resp_valid); end
        checks++; if (bus.host_resp_data !== 64'd0) begin failures++; $display("FAIL reset_resp_data got=%h exp=0", bus.host_resp_data); end
        checks++; if (bus.pcr_en !== 1'b0) begin failures++; $display("FAIL reset_pcr_en got=%b exp=0", bus.pcr_en); end
        checks++; if (bus.pcr_wen !== 1'b0) begin failures++; $display("FAIL reset_pcr_wen got=%b exp=0", bus.pcr_wen); end
        checks++; if (bus.pcr_addr !== 5'd0) begin failures++; $display("FAIL reset_pcr_addr got=%h exp=0", bus.pcr_addr); end
        checks++; if (bus.pcr_wdata !== 64'd0) begin failures++; $display("FAIL reset_pcr_wdata got=%h exp=0", bus.pcr_wdata); end
        reset = 1'b0;
        tick();
        checks++; if (bus.host_req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", bus.host_req_ready); end
    endtask

    task automatic test_read();
        bus.host_req_valid = 1'b1;
        bus.host_req_rw    = 1'b0;
        bus.host_req_addr  = 5'd3;
        bus.host_req_data  = 64'd0;
        checks++; if (bus.host_req_ready !== 1'b1) begin failures++; $display("FAIL read_ready got=%b exp=1", bus.host_req_ready); end
        tick();  // accept edge: now cycle N+1
        bus.host_req_valid = 1'b0;
        checks++; if (bus.pcr_en !== 1'b0) begin failures++; $display("FAIL read_en_n1 got=%b exp=0", bus.pcr_en); end
        tick();  // N+2
        checks++; if (bus.pcr_en !== 1'b1 || bus.pcr_wen !== 1'b0 || bus.pcr_addr !== 5'd3) begin
            failures++; $display("FAIL read_issue got en=%b wen=%b addr=%0d exp en=1 wen=0 addr=3", bus.pcr_en, bus.pcr_wen, bus.pcr_addr); end
        checks++; if (bus.host_resp_valid !== 1'b0) begin failures++; $display("FAIL read_valid_n2 got=%b exp=0", bus.host_resp_valid); end
        tick();  // N+3
        checks++; if (bus.host_resp_valid !== 1'b1 || bus.host_resp_data !== 64'h0000_0000_0000_00A5) begin
            failures++; $display("FAIL read_resp got valid=%b data=%h exp valid=1 data=00000000000000a5", bus.host_resp_valid, bus.host_resp_data); end
        tick();  // response held while host stalls
        checks++; if (bus.host_resp_valid !== 1'b1 || bus.host_resp_data !== 64'hA5 || bus.pcr_en !== 1'b0) begin
            failures++; $display("FAIL read_hold got valid=%b data=%h en=%b exp valid=1 data=a5 en=0", bus.host_resp_valid, bus.host_resp_data, bus.pcr_en); end
        bus.host_resp_ready = 1'b1;
        tick();
        bus.host_resp_ready = 1'b0;
        checks++; if (bus.host_resp_valid !== 1'b0) begin failures++; $display("FAIL read_done got=%b exp=0", bus.host_resp_valid); end
    endtask

    task automatic test_write_swap();
        bus.host_req_valid = 1'b1;
        bus.host_req_rw    = 1'b1;
        bus.host_req_addr  = 5'd0;
        bus.host_req_data  = 64'h42;
        tick();
        bus.host_req_valid = 1'b0;
        tick();
        checks++; if (bus.pcr_en !== 1'b1 || bus.pcr_wen !== 1'b1 || bus.pcr_wdata !== 64'h42) begin
            failures++; $display("FAIL write_issue got en=%b wen=%b wdata=%h exp en=1 wen=1 wdata=42", bus.pcr_en, bus.pcr_wen, bus.pcr_wdata); end
        tick();
        checks++; if (bus.host_resp_valid !== 1'b1 || bus.host_resp_data !== 64'h11) begin
            failures++; $display("FAIL write_old_value got valid=%b data=%h exp valid=1 data=11", bus.host_resp_valid, bus.host_resp_data); end
        checks++; if (pcr_mem[0] !== 64'h42) begin failures++; $display("FAIL write_effect got=%h exp=42", pcr_mem[0]); end
        bus.host_resp_ready = 1'b1;
        tick();
        // Follow-up read of the same register returns the new value.
        bus.host_req_valid = 1'b1;
        bus.host_req_rw    = 1'b0;
        bus.host_req_data  = 64'd0;
        tick();
        bus.host_req_valid  = 1'b0;
        bus.host_resp_ready = 1'b0;
        tick();
        tick();
        checks++; if (bus.host_resp_valid !== 1'b1 || bus.host_resp_data !== 64'h42) begin
            failures++; $display("FAIL write_readback got valid=%b data=%h exp valid=1 data=42", bus.host_resp_valid, bus.host_resp_data); end
        bus.host_resp_ready = 1'b1;
        tick();
        bus.host_resp_ready = 1'b0;
    endtask

    task automatic test_backpressure_and_full_pop();
        int               acc = 0;
        int               idx = 0;
        logic             took;
        logic [DATA_W-1:0] got_q [$];
        int               en_q [$];
        logic [DATA_W-1:0] exp_data [3];
        exp_data[0] = val2;
        exp_data[1] = val4;
        exp_data[2] = val5;
        bus.host_resp_ready = 1'b0;
        bus.host_req_rw     = 1'b0;
        bus.host_req_data   = 64'd0;
        for (int i = 0; i < 8; i++) begin
            bus.host_req_valid = 1'b1;
            bus.host_req_addr  = req_addr[idx];
            took = bus.host_req_ready;
            tick();
            if (took) begin
                acc++;
                if (idx < 3) idx++;
            end
        end
        bus.host_req_addr = req_addr[idx];
        checks++; if (acc !== 3) begin failures++; $display("FAIL bp_accepted got=%0d exp=3", acc); end
        checks++; if (bus.host_req_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%b exp=0", bus.host_req_ready); end
        checks++; if (bus.host_resp_valid !== 1'b1 || bus.host_resp_data !== val1) begin
            failures++; $display("FAIL bp_first_resp got valid=%b data=%h exp valid=1 data=%h", bus.host_resp_valid, bus.host_resp_data, val1); end
        // FIFO full: pop and a new request in the same cycle.
        bus.host_resp_ready = 1'b1;
        checks++; if (bus.host_req_ready !== 1'b0) begin failures++; $display("FAIL fullpop_same_cycle got=%b exp=0", bus.host_req_ready); end
        tick();
        checks++; if (bus.host_req_ready !== 1'b1) begin failures++; $display("FAIL fullpop_next_cycle got=%b exp=1", bus.host_req_ready); end
        for (int i = 0; i < 16; i++) begin
            if (bus.pcr_en) en_q.push_back(i);
            if (bus.host_resp_valid) got_q.push_back(bus.host_resp_data);
            took = bus.host_req_valid && bus.host_req_ready;
            tick();
            if (took) bus.host_req_valid = 1'b0;
        end
        checks++; if (got_q.size() !== 3 || en_q.size() !== 3) begin
            failures++; $display("FAIL drain_counts got resp=%0d en=%0d exp resp=3 en=3", got_q.size(), en_q.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < got_q.size()) begin
                checks++; if (got_q[k] !== exp_data[k]) begin failures++; $display("FAIL drain_order[%0d] got=%h exp=%h", k, got_q[k], exp_data[k]); end
            end
            if (k < en_q.size()) begin
                checks++; if (en_q[k] !== 2 * k) begin failures++; $display("FAIL drain_spacing[%0d] got=%0d exp=%0d", k, en_q[k], 2 * k); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int en_cnt = 0;
        int val_cnt = 0;
        bus.host_resp_ready = 1'b0;
        bus.host_req_rw     = 1'b0;
        bus.host_req_valid  = 1'b1;
        bus.host_req_addr   = 5'd6;
        tick();
        bus.host_req_addr   = 5'd7;
        tick();
        bus.host_req_valid  = 1'b0;
        checks++; if (bus.pcr_en !== 1'b1 || bus.pcr_addr !== 5'd6) begin
            failures++; $display("FAIL rst_mid_issue got en=%b addr=%0d exp en=1 addr=6", bus.pcr_en, bus.pcr_addr); end
        reset = 1'b1;
        tick();
        checks++; if (bus.pcr_en !== 1'b0) begin failures++; $display("FAIL rst_mid_en got=%b exp=0", bus.pcr_en); end
        checks++; if (bus.host_resp_valid !== 1'b0 || bus.host_resp_data !== 64'd0) begin
            failures++; $display("FAIL rst_mid_resp got valid=%b data=%h exp valid=0 data=0", bus.host_resp_valid, bus.host_resp_data); end
        checks++; if (bus.host_req_ready !== 1'b0 || bus.pcr_addr !== 5'd0) begin
            failures++; $display("FAIL rst_mid_ready_addr got ready=%b addr=%0d exp ready=0 addr=0", bus.host_req_ready, bus.pcr_addr); end
        reset = 1'b0;
        tick();
        checks++; if (bus.host_req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_release_ready got=%b exp=1", bus.host_req_ready); end
        bus.host_resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bus.pcr_en) en_cnt++;
            if (bus.host_resp_valid) val_cnt++;
            tick();
        end
        checks++; if (en_cnt !== 0 || val_cnt !== 0) begin
            failures++; $display("FAIL rst_mid_stale got en=%0d resp=%0d exp en=0 resp=0", en_cnt, val_cnt); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_swap();
        test_backpressure_and_full_pop();
        test_reset_mid();
        checks++; if (overlap_err !== 0) begin failures++; $display("FAIL en_during_resp got=%0d exp=0", overlap_err); end
        checks++; if (toggle_err !== 0) begin failures++; $display("FAIL port_toggle_outside_issue got=%0d exp=0", toggle_err); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pcr_host_bridge.md
# pcr_host_bridge

Upstream feeder for the processor-control-register (PCR) file. It accepts host PCR requests on a valid/ready port and buffers them in a small FIFO. Each request is issued to the PCR file as a single-cycle access, and the register's pre-access value is returned on a valid/ready response port. Every access has swap semantics: reads and writes both return the old value, and a write also updates the register.

## Interface

Parameters:
- ADDR_W, 5, PCR address width
- DATA_W, 64, PCR data width
- DEPTH, 2, request FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- host_req_valid  in  1  request present
- host_req_ready  out  1  bridge accepts the request this cycle
- host_req_rw  in  1  1 = write, 0 = read
- host_req_addr  in  ADDR_W  PCR index
- host_req_data  in  DATA_W  write data; ignored for reads
- host_resp_valid  out  1  response present
- host_resp_ready  in  1  host takes the response
- host_resp_data  out  DATA_W  PCR value before the access
- pcr_en  out  1  single-cycle access strobe
- pcr_wen  out  1  write qualifier; meaningful only with pcr_en
- pcr_addr  out  ADDR_W  access address
- pcr_wdata  out  DATA_W  write data
- pcr_rdata  in  DATA_W  combinational read of pcr_addr, valid in the pcr_en cycle

## Operation

- Request handshake:
  - Accept occurs when host_req_valid && host_req_ready.
  - {rw, addr, data} is pushed into the FIFO.
  - host_req_ready = !reset && (count < DEPTH), computed from the registered count.
  - There is no fall-through: a pop in the same cycle does not raise ready while the FIFO is full.
- FSM states are IDLE, ISSUE and RESP. Reset state is IDLE.
- IDLE:
  - If the FIFO is non-empty: pop the head into the issue registers and go to ISSUE.
- ISSUE:
  - pcr_en=1 for exactly one cycle; pcr_wen=rw; pcr_addr and pcr_wdata come from the issue registers.
  - Capture pcr_rdata into the response register.
  - Go to RESP.
- RESP:
  - host_resp_valid=1 and host_resp_data is held stable until the handshake.
  - On host_resp_ready: if the FIFO is non-empty, pop and go to ISSUE; otherwise go to IDLE.
- pcr_addr, pcr_wdata and pcr_wen must not toggle outside ISSUE. They hold their last values, which avoids spurious read-port activity.
- Order: requests complete strictly in acceptance order, and exactly one response is produced per request.
- Simultaneous push and pop:
  - Legal whenever count < DEPTH.
  - Count is unchanged.
  - The popped entry is the old head, never the entry being pushed.
- Reset mid-operation:
  - Flushes the FIFO, returns the FSM to IDLE and drops any pending response.
  - pcr_en is never asserted in the cycle following reset assertion.

## Timing

- Reset values: host_req_ready=0 while reset is high, then 1; host_resp_valid=0; host_resp_data=0; pcr_en=0; pcr_wen=0; pcr_addr=0; pcr_wdata=0; count=0.
- Accept at cycle N (empty FIFO, FSM in IDLE):
  - Pop in cycle N+1.
  - pcr_en in cycle N+2.
  - host_resp_valid from cycle N+3.
- With host_resp_ready held high, back-to-back requests issue every 2 cycles: one pcr_en per 2 cycles.
- Write effect: the PCR file updates at the clk edge that closes the pcr_en cycle. host_resp_data carries the value prior to that edge.
- FIFO pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.

## Structure

- Shared package pcr_bridge_pkg holds:
  - the state enum (IDLE, ISSUE, RESP);
  - the pcr_req_t struct {rw, addr[ADDR_W], data[DATA_W]};
  - the default ADDR_W and DATA_W constants.
- Sub-module pcr_req_fifo provides a synchronous FIFO:
  - Inputs: push, pop, din.
  - Outputs: dout (head, combinational), full, empty.
  - The FSM and handshake logic stay in pcr_host_bridge.

## Test plan

- Read:
  - Stimulus: PCR model holds 0xA5 at addr 3; send a read of addr 3.
  - Response: pcr_en one cycle with wen=0 and addr=3; host_resp_data=0x00000000000000A5 at N+3.
- Write-swap:
  - Stimulus: addr 0 holds 0x11; write 0x42 to addr 0.
  - Response: resp=0x11; a following read of addr 0 returns 0x42.
- Backpressure:
  - Stimulus: hold host_resp_ready=0 and push 4 requests.
  - Response: DEPTH=2 entries are accepted while one request sits in RESP; then ready=0.
  - Release: responses drain in order at 1 per 2 cycles; no pcr_en occurs while in RESP.
- Full-boundary push/pop:
  - Stimulus: with the FIFO full, pop and present a new request in the same cycle.
  - Response: the request is not accepted that cycle (ready=0); it is accepted the next cycle.
- Reset mid-operation:
  - Stimulus: assert reset during ISSUE with 2 entries queued.
  - Response: next cycle pcr_en=0, resp_valid=0 and FIFO empty; after release, ready=1 and no stale responses appear.
